// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - reservation-station allocate and round-robin issue controller
module rs_issue_sched #(
    parameter int NUM_RS     = 4,
    parameter int IDX_BITS   = 2,
    parameter int FU_CREDITS = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_RS-1:0]   rs_avail_in,
    input  logic [NUM_RS-1:0]   rs_ready_in,
    input  logic                dispatch_valid,
    output logic                dispatch_stall,
    output logic [NUM_RS-1:0]   rs_load_out,
    output logic [NUM_RS-1:0]   rs_use_enable_out,
    output logic [NUM_RS-1:0]   rs_free_out,
    output logic                fu_issue_valid,
    output logic [IDX_BITS-1:0] fu_issue_idx,
    input  logic                fu_done,
    input  logic                flush
);

    localparam int                PW         = IDX_BITS + 1;
    localparam logic [2:0]        CREDIT_MAX = 3'(FU_CREDITS);
    localparam logic [PW-1:0]     NUM_RS_W   = PW'(NUM_RS);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_RS - 1);

    logic                issue_valid_q;
    logic [IDX_BITS-1:0] issue_idx_q;
    logic [IDX_BITS-1:0] rr_ptr;
    logic [2:0]          credits;
    logic                flush_q;

    logic                alloc_ok;
    logic                alloc_found;
    logic [NUM_RS-1:0]   issue_mask;
    logic [NUM_RS-1:0]   cand;
    logic [PW-1:0]       pos;
    logic                sel_found;
    logic [IDX_BITS-1:0] sel_idx;
    logic                sel_fire;
    logic                done_eff;
    logic [IDX_BITS-1:0] rr_next;

    // Loads are blocked during a flush and the cycle after, and held off in reset.
    assign alloc_ok       = dispatch_valid & ~flush & ~flush_q & ~reset;
    assign dispatch_stall = dispatch_valid & ~reset &
                            ((rs_avail_in == '0) | flush | flush_q);

    // Allocation: the lowest-index free entry takes the dispatched instruction.
    always_comb begin
        rs_load_out = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (alloc_ok && !alloc_found && rs_avail_in[i]) begin
                rs_load_out[i] = 1'b1;
                alloc_found    = 1'b1;
            end
        end
    end

    // The entry being driven still shows ready until its InUse clears, so hide it.
    assign issue_mask = issue_valid_q ? (NUM_RS'(1) << issue_idx_q) : '0;
    assign cand       = rs_ready_in & ~issue_mask;

    // Round-robin select: first candidate at or above rr_ptr, wrapping to entry 0.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        pos       = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            pos = {1'b0, rr_ptr} + PW'(i);
            if (pos >= NUM_RS_W) begin
                pos = pos - NUM_RS_W;
            end
            if (!sel_found && cand[pos[IDX_BITS-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = pos[IDX_BITS-1:0];
            end
        end
    end

    assign sel_fire = sel_found & (credits != 3'd0) & ~flush & ~flush_q;
    assign done_eff = fu_done & (credits != CREDIT_MAX);
    assign rr_next  = (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_BITS'(1);

    // Issue register, round-robin pointer, flush delay and FU credit counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            rr_ptr        <= '0;
            credits       <= CREDIT_MAX;
            flush_q       <= 1'b0;
        end else begin
            flush_q       <= flush;
            issue_valid_q <= sel_fire;
            if (sel_fire) begin
                issue_idx_q <= sel_idx;
                rr_ptr      <= rr_next;
            end
            if (flush) begin
                credits <= CREDIT_MAX;
            end else if (sel_fire && !done_eff) begin
                credits <= credits - 3'd1;
            end else if (done_eff && !sel_fire) begin
                credits <= credits + 3'd1;
            end
        end
    end

    assign rs_use_enable_out = issue_mask;
    assign rs_free_out       = issue_mask | {NUM_RS{flush_q}};
    assign fu_issue_valid    = issue_valid_q;
    assign fu_issue_idx      = issue_valid_q ? issue_idx_q : '0;

endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - directed self-checking bench for rs_issue_sched
module tb_rs_issue_sched;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] rs_avail_in;
    logic [3:0] rs_ready_in;
    logic       dispatch_valid;
    logic       dispatch_stall;
    logic [3:0] rs_load_out;
    logic [3:0] rs_use_enable_out;
    logic [3:0] rs_free_out;
    logic       fu_issue_valid;
    logic [1:0] fu_issue_idx;
    logic       fu_done;
    logic       flush;

    logic [15:0] obs;
    int checks   = 0;
    int failures = 0;

    rs_issue_sched #(
        .NUM_RS     (4),
        .IDX_BITS   (2),
        .FU_CREDITS (2)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .rs_avail_in       (rs_avail_in),
        .rs_ready_in       (rs_ready_in),
        .dispatch_valid    (dispatch_valid),
        .dispatch_stall    (dispatch_stall),
        .rs_load_out       (rs_load_out),
        .rs_use_enable_out (rs_use_enable_out),
        .rs_free_out       (rs_free_out),
        .fu_issue_valid    (fu_issue_valid),
        .fu_issue_idx      (fu_issue_idx),
        .fu_done           (fu_done),
        .flush             (flush)
    );

    always #5 clock = ~clock;

    // Observed vector: {load[3:0], stall, use_enable[3:0], free[3:0], issue_valid, issue_idx[1:0]}
    assign obs = {rs_load_out, dispatch_stall, rs_use_enable_out, rs_free_out,
                  fu_issue_valid, fu_issue_idx};

    // Stimulus vector: {reset, flush, fu_done, dispatch_valid, avail[3:0], ready[3:0]}
    task automatic drive(input logic [11:0] x);
        {reset, flush, fu_done, dispatch_valid, rs_avail_in, rs_ready_in} = x;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(12'b1000_0000_0000);
        step();
        step();
    endtask

    task automatic test_reset();
        logic [11:0] st [3];
        logic [15:0] ex [3];
        st = '{12'b1000_0000_0000, 12'b1000_0000_1111, 12'b0000_0000_0000};
        ex = '{16'b0000_0_0000_0000_0_00, 16'b0000_0_0000_0000_0_00,
               16'b0000_0_0000_0000_0_00};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(st[c]);
            #1;
            checks++;
            if (obs !== ex[c]) begin
                failures++;
                $display("FAIL reset cycle=%0d got=%b expected=%b", c, obs, ex[c]);
            end
            step();
        end
    endtask

    task automatic test_dispatch_fill();
        logic [11:0] st [7];
        logic [15:0] ex [7];
        st = '{12'b0001_1111_0000, 12'b0001_1110_0000, 12'b0001_1100_0000,
               12'b0001_1000_0000, 12'b0001_0000_0000, 12'b0000_0000_0000,
               12'b0001_1010_0000};
        ex = '{16'b0001_0_0000_0000_0_00, 16'b0010_0_0000_0000_0_00,
               16'b0100_0_0000_0000_0_00, 16'b1000_0_0000_0000_0_00,
               16'b0000_1_0000_0000_0_00, 16'b0000_0_0000_0000_0_00,
               16'b0010_0_0000_0000_0_00};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(st[c]);
            #1;
            checks++;
            if (obs !== ex[c]) begin
                failures++;
                $display("FAIL dispatch_fill cycle=%0d got=%b expected=%b", c, obs, ex[c]);
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] ex [6];
        ex = '{16'b0000_0_0000_0000_0_00, 16'b0000_0_0001_0001_1_00,
               16'b0000_0_0010_0010_1_01, 16'b0000_0_0100_0100_1_10,
               16'b0000_0_1000_1000_1_11, 16'b0000_0_0001_0001_1_00};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(12'b0010_0000_1111);
            #1;
            checks++;
            if (obs !== ex[c]) begin
                failures++;
                $display("FAIL round_robin cycle=%0d got=%b expected=%b", c, obs, ex[c]);
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [11:0] st [8];
        logic [15:0] ex [8];
        st = '{12'b0010_0000_0100, 12'b0010_0000_0000, 12'b0010_0000_0100,
               12'b0010_0000_0000, 12'b0010_0000_1001, 12'b0010_0000_0000,
               12'b0010_0000_1001, 12'b0010_0000_0000};
        ex = '{16'b0000_0_0000_0000_0_00, 16'b0000_0_0100_0100_1_10,
               16'b0000_0_0000_0000_0_00, 16'b0000_0_0100_0100_1_10,
               16'b0000_0_0000_0000_0_00, 16'b0000_0_1000_1000_1_11,
               16'b0000_0_0000_0000_0_00, 16'b0000_0_0001_0001_1_00};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(st[c]);
            #1;
            checks++;
            if (obs !== ex[c]) begin
                failures++;
                $display("FAIL rr_wrap cycle=%0d got=%b expected=%b", c, obs, ex[c]);
            end
            step();
        end
    endtask

    task automatic test_issue_latency();
        logic [11:0] st [6];
        logic [15:0] ex [6];
        st = '{12'b0000_0000_0000, 12'b0000_0000_0000, 12'b0000_0000_0000,
               12'b0000_0000_0010, 12'b0000_0000_0010, 12'b0000_0000_0000};
        ex = '{16'b0000_0_0000_0000_0_00, 16'b0000_0_0000_0000_0_00,
               16'b0000_0_0000_0000_0_00, 16'b0000_0_0000_0000_0_00,
               16'b0000_0_0010_0010_1_01, 16'b0000_0_0000_0000_0_00};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(st[c]);
            #1;
            checks++;
            if (obs !== ex[c]) begin
                failures++;
                $display("FAIL issue_latency cycle=%0d got=%b expected=%b", c, obs, ex[c]);
            end
            step();
        end
    endtask

    task automatic test_credit_stall();
        logic [11:0] st [10];
        logic [15:0] ex [10];
        st = '{12'b0010_0000_0000, 12'b0010_0000_0000, 12'b0000_0000_1111,
               12'b0000_0000_1111, 12'b0000_0000_1111, 12'b0000_0000_1111,
               12'b0010_0000_1111, 12'b0000_0000_1111, 12'b0000_0000_1111,
               12'b0000_0000_1111};
        ex = '{16'b0000_0_0000_0000_0_00, 16'b0000_0_0000_0000_0_00,
               16'b0000_0_0000_0000_0_00, 16'b0000_0_0001_0001_1_00,
               16'b0000_0_0010_0010_1_01, 16'b0000_0_0000_0000_0_00,
               16'b0000_0_0000_0000_0_00, 16'b0000_0_0000_0000_0_00,
               16'b0000_0_0100_0100_1_10, 16'b0000_0_0000_0000_0_00};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(st[c]);
            #1;
            checks++;
            if (obs !== ex[c]) begin
                failures++;
                $display("FAIL credit_stall cycle=%0d got=%b expected=%b", c, obs, ex[c]);
            end
            step();
        end
    endtask

    task automatic test_flush();
        logic [11:0] st [7];
        logic [15:0] ex [7];
        st = '{12'b0000_0000_0110, 12'b0101_1111_0110, 12'b0001_1111_0110,
               12'b0001_1111_0110, 12'b0000_0000_0110, 12'b0000_0000_0110,
               12'b0000_0000_0110};
        ex = '{16'b0000_0_0000_0000_0_00, 16'b0000_1_0010_0010_1_01,
               16'b0000_1_0000_1111_0_00, 16'b0001_0_0000_0000_0_00,
               16'b0000_0_0100_0100_1_10, 16'b0000_0_0010_0010_1_01,
               16'b0000_0_0000_0000_0_00};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(st[c]);
            #1;
            checks++;
            if (obs !== ex[c]) begin
                failures++;
                $display("FAIL flush cycle=%0d got=%b expected=%b", c, obs, ex[c]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] st [5];
        logic [15:0] ex [5];
        st = '{12'b0000_0000_0100, 12'b1000_0000_0100, 12'b0000_0000_0000,
               12'b0000_0000_1001, 12'b0000_0000_0000};
        ex = '{16'b0000_0_0000_0000_0_00, 16'b0000_0_0100_0100_1_10,
               16'b0000_0_0000_0000_0_00, 16'b0000_0_0000_0000_0_00,
               16'b0000_0_0001_0001_1_00};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(st[c]);
            #1;
            checks++;
            if (obs !== ex[c]) begin
                failures++;
                $display("FAIL reset_mid cycle=%0d got=%b expected=%b", c, obs, ex[c]);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_dispatch_fill();
        test_round_robin();
        test_wrap();
        test_issue_latency();
        test_credit_stall();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
